// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: transfer direction,
// transfer length codes, transaction owner codes and FSM state codes.
package mem_req_arbiter_pkg;

    // memctrl transfer direction
    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    // memctrl transfer length in bytes
    localparam logic [2:0] LEN_ONE  = 3'd1;
    localparam logic [2:0] LEN_TWO  = 3'd2;
    localparam logic [2:0] LEN_FOUR = 3'd4;

    // Which requester owns the current memctrl transaction
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } owner_e;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_req_arbiter_prio.sv
// Combinational grant selection: store beats load beats fetch, except that a
// starved fetch is forced through and a store to a full IO buffer steps aside.
module mem_req_arbiter_prio
    import mem_req_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   ld_req,
    input  logic   st_req,
    input  logic   flush,
    input  logic   starve,
    input  logic   io_block,
    output owner_e grant
);

    logic if_ok;
    logic st_ok;

    assign if_ok = if_req && !flush;
    assign st_ok = st_req && !io_block;

    // Pick the winning requester for this cycle
    always_comb begin
        grant = OWN_NONE;
        if (starve && if_ok) begin
            grant = OWN_IF;
        end else if (st_ok) begin
            grant = OWN_ST;
        end else if (ld_req) begin
            grant = OWN_LD;
        end else if (if_ok) begin
            grant = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Three-way arbiter/sequencer in front of the byte-serial memory controller.
// One transaction at a time: latch the winner, hold it on memctrl until done,
// then return a one-cycle done pulse with data to the owner.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int         ADDR_W       = 32,
    parameter int         DATA_W       = 32,
    parameter int         STARVE_LIMIT = 4,
    parameter logic [1:0] IO_PREFIX    = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iIO_buffer_full,
    input  logic              iFLUSH,
    input  logic              iIF_req,
    input  logic [ADDR_W-1:0] iIF_addr,
    output logic              oIF_done,
    output logic [DATA_W-1:0] oIF_inst,
    input  logic              iLD_req,
    input  logic [ADDR_W-1:0] iLD_addr,
    input  logic [2:0]        iLD_len,
    output logic              oLD_done,
    output logic [DATA_W-1:0] oLD_dt,
    input  logic              iST_req,
    input  logic [ADDR_W-1:0] iST_addr,
    input  logic [2:0]        iST_len,
    input  logic [DATA_W-1:0] iST_dt,
    output logic              oST_done,
    output logic              oMC_en,
    output logic              oMC_ls,
    output logic [2:0]        oMC_len,
    output logic [ADDR_W-1:0] oMC_addr,
    output logic [DATA_W-1:0] oMC_dt,
    input  logic              iMC_done,
    input  logic [DATA_W-1:0] iMC_dt
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e           state;
    owner_e           owner;
    owner_e           grant;
    logic [CNT_W-1:0] starve_cnt;
    logic             discard;
    logic             io_block;
    logic             starve;

    // Loads return only the requested bytes; sign extension happens downstream
    function automatic logic [DATA_W-1:0] zext_load(input logic [2:0] len,
                                                    input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] res;
        res = raw;
        if (len == LEN_ONE) begin
            res = {{(DATA_W-8){1'b0}}, raw[7:0]};
        end else if (len == LEN_TWO) begin
            res = {{(DATA_W-16){1'b0}}, raw[15:0]};
        end
        return res;
    endfunction

    assign io_block = iIO_buffer_full && (iST_addr[17:16] == IO_PREFIX);
    assign starve   = (starve_cnt == CNT_MAX);

    mem_req_arbiter_prio u_prio (
        .if_req   (iIF_req),
        .ld_req   (iLD_req),
        .st_req   (iST_req),
        .flush    (iFLUSH),
        .starve   (starve),
        .io_block (io_block),
        .grant    (grant)
    );

    // Count data grants made while a fetch is left waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rdy) begin
            if (!iIF_req) begin
                starve_cnt <= '0;
            end else if (state == S_IDLE) begin
                if (grant == OWN_IF) begin
                    starve_cnt <= '0;
                end else if ((grant == OWN_ST || grant == OWN_LD) && starve_cnt < CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    // Sequencer: grant and latch in IDLE, hold memctrl request in BUSY,
    // pulse the owner's done in RESP. A flushed fetch still runs to completion
    // on memctrl; only its done pulse is swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= OWN_NONE;
            discard  <= 1'b0;
            oMC_en   <= 1'b0;
            oMC_ls   <= LS_LOAD;
            oMC_len  <= '0;
            oMC_addr <= '0;
            oMC_dt   <= '0;
            oIF_done <= 1'b0;
            oIF_inst <= '0;
            oLD_done <= 1'b0;
            oLD_dt   <= '0;
            oST_done <= 1'b0;
        end else if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (grant != OWN_NONE) begin
                        owner  <= grant;
                        oMC_en <= 1'b1;
                        state  <= S_BUSY;
                        case (grant)
                            OWN_ST: begin
                                oMC_ls   <= LS_STORE;
                                oMC_len  <= iST_len;
                                oMC_addr <= iST_addr;
                                oMC_dt   <= iST_dt;
                            end
                            OWN_LD: begin
                                oMC_ls   <= LS_LOAD;
                                oMC_len  <= iLD_len;
                                oMC_addr <= iLD_addr;
                                oMC_dt   <= '0;
                            end
                            OWN_IF: begin
                                oMC_ls   <= LS_LOAD;
                                oMC_len  <= LEN_FOUR;
                                oMC_addr <= iIF_addr;
                                oMC_dt   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    if (iMC_done) begin
                        oMC_en <= 1'b0;
                        state  <= S_RESP;
                        case (owner)
                            OWN_IF: begin
                                if (!(discard || iFLUSH)) begin
                                    oIF_done <= 1'b1;
                                    oIF_inst <= iMC_dt;
                                end
                            end
                            OWN_LD: begin
                                oLD_done <= 1'b1;
                                oLD_dt   <= zext_load(oMC_len, iMC_dt);
                            end
                            OWN_ST: oST_done <= 1'b1;
                            default: ;
                        endcase
                    end else if (iFLUSH && owner == OWN_IF) begin
                        discard <= 1'b1;
                    end
                end
                S_RESP: begin
                    oIF_done <= 1'b0;
                    oIF_inst <= '0;
                    oLD_done <= 1'b0;
                    oLD_dt   <= '0;
                    oST_done <= 1'b0;
                    discard  <= 1'b0;
                    owner    <= OWN_NONE;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: the bench plays memctrl and the three
// requesters, with hand-computed expected grants, done pulses and data.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        iIO_buffer_full;
    logic        iFLUSH;
    logic        iIF_req;
    logic [31:0] iIF_addr;
    logic        oIF_done;
    logic [31:0] oIF_inst;
    logic        iLD_req;
    logic [31:0] iLD_addr;
    logic [2:0]  iLD_len;
    logic        oLD_done;
    logic [31:0] oLD_dt;
    logic        iST_req;
    logic [31:0] iST_addr;
    logic [2:0]  iST_len;
    logic [31:0] iST_dt;
    logic        oST_done;
    logic        oMC_en;
    logic        oMC_ls;
    logic [2:0]  oMC_len;
    logic [31:0] oMC_addr;
    logic [31:0] oMC_dt;
    logic        iMC_done;
    logic [31:0] iMC_dt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .iIO_buffer_full (iIO_buffer_full),
        .iFLUSH          (iFLUSH),
        .iIF_req         (iIF_req),
        .iIF_addr        (iIF_addr),
        .oIF_done        (oIF_done),
        .oIF_inst        (oIF_inst),
        .iLD_req         (iLD_req),
        .iLD_addr        (iLD_addr),
        .iLD_len         (iLD_len),
        .oLD_done        (oLD_done),
        .oLD_dt          (oLD_dt),
        .iST_req         (iST_req),
        .iST_addr        (iST_addr),
        .iST_len         (iST_len),
        .iST_dt          (iST_dt),
        .oST_done        (oST_done),
        .oMC_en          (oMC_en),
        .oMC_ls          (oMC_ls),
        .oMC_len         (oMC_len),
        .oMC_addr        (oMC_addr),
        .oMC_dt          (oMC_dt),
        .iMC_done        (iMC_done),
        .iMC_dt          (iMC_dt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for memctrl request and check the latched fields
    task automatic waitGrant(input string tag, input logic [31:0] addr, input logic ls,
                             input logic [2:0] len, input logic [31:0] dt);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oMC_en) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, " grant"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            checkOutput({tag, " addr"}, oMC_addr, addr);
            checkOutput({tag, " ls"}, {31'b0, oMC_ls}, {31'b0, ls});
            checkOutput({tag, " len"}, {29'b0, oMC_len}, {29'b0, len});
            checkOutput({tag, " dt"}, oMC_dt, dt);
        end
    endtask

    // Act as memctrl: finish after 'delay' cycles, then check the done pulse
    // ({IF,LD,ST}) and returned data during RESP and its removal afterwards
    task automatic finishTxn(input string tag, input int delay, input logic [31:0] mc_data,
                             input logic [2:0] exp_done, input logic [31:0] exp_inst,
                             input logic [31:0] exp_ld);
        tick(delay);
        checkOutput({tag, " en held"}, {31'b0, oMC_en}, 32'd1);
        iMC_done = 1'b1;
        iMC_dt   = mc_data;
        @(negedge clk);
        iMC_done = 1'b0;
        iMC_dt   = '0;
        checkOutput({tag, " done"}, {29'b0, oIF_done, oLD_done, oST_done}, {29'b0, exp_done});
        checkOutput({tag, " en off"}, {31'b0, oMC_en}, 32'd0);
        checkOutput({tag, " inst"}, oIF_inst, exp_inst);
        checkOutput({tag, " ld_dt"}, oLD_dt, exp_ld);
        @(negedge clk);
        checkOutput({tag, " done clr"}, {29'b0, oIF_done, oLD_done, oST_done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; iIO_buffer_full = 1'b0; iFLUSH = 1'b0;
        iIF_req = 1'b0; iIF_addr = '0; iLD_req = 1'b0; iLD_addr = '0; iLD_len = '0;
        iST_req = 1'b0; iST_addr = '0; iST_len = '0; iST_dt = '0;
        iMC_done = 1'b0; iMC_dt = '0;
        tick(3);
        checkOutput("reset en", {31'b0, oMC_en}, 32'd0);
        checkOutput("reset done", {29'b0, oIF_done, oLD_done, oST_done}, 32'd0);
        checkOutput("reset addr", oMC_addr, 32'd0);
        rst = 1'b0;
        tick(1);

        // Lone fetch
        $display("[TB] lone fetch");
        iIF_req = 1'b1; iIF_addr = 32'h100;
        waitGrant("if1", 32'h100, 1'b0, 3'd4, 32'h0);
        finishTxn("if1", 5, 32'h00A00093, 3'b100, 32'h00A00093, 32'h0);
        iIF_req = 1'b0;
        tick(2);

        // Simultaneous store, load and fetch
        $display("[TB] priority order");
        iST_req = 1'b1; iST_addr = 32'h200; iST_len = 3'd4; iST_dt = 32'hDEADBEEF;
        iLD_req = 1'b1; iLD_addr = 32'h300; iLD_len = 3'd2;
        iIF_req = 1'b1; iIF_addr = 32'h104;
        waitGrant("st2", 32'h200, 1'b1, 3'd4, 32'hDEADBEEF);
        finishTxn("st2", 2, 32'h0, 3'b001, 32'h0, 32'h0);
        iST_req = 1'b0;
        waitGrant("ld2", 32'h300, 1'b0, 3'd2, 32'h0);
        finishTxn("ld2", 2, 32'h12345678, 3'b010, 32'h0, 32'h00005678);
        iLD_req = 1'b0;
        waitGrant("if2", 32'h104, 1'b0, 3'd4, 32'h0);
        finishTxn("if2", 1, 32'h00000013, 3'b100, 32'h00000013, 32'h0);
        iIF_req = 1'b0;
        tick(2);

        // Fetch starvation: forced after the fourth load
        $display("[TB] starvation");
        iLD_req = 1'b1; iLD_addr = 32'h800; iLD_len = 3'd1;
        iIF_req = 1'b1; iIF_addr = 32'h900;
        for (int k = 0; k < 4; k++) begin
            waitGrant($sformatf("ld3_%0d", k), 32'h800, 1'b0, 3'd1, 32'h0);
            finishTxn($sformatf("ld3_%0d", k), 1, 32'hAABBCCDD, 3'b010, 32'h0, 32'h000000DD);
        end
        waitGrant("if3", 32'h900, 1'b0, 3'd4, 32'h0);
        finishTxn("if3", 1, 32'h00100113, 3'b100, 32'h00100113, 32'h0);
        iIF_addr = 32'h904;
        waitGrant("ld3_4", 32'h800, 1'b0, 3'd1, 32'h0);
        finishTxn("ld3_4", 1, 32'h11223344, 3'b010, 32'h0, 32'h00000044);
        iLD_req = 1'b0;
        waitGrant("if3b", 32'h904, 1'b0, 3'd4, 32'h0);
        finishTxn("if3b", 1, 32'h00200193, 3'b100, 32'h00200193, 32'h0);
        iIF_req = 1'b0;
        tick(2);

        // IO store blocked by full buffer
        $display("[TB] io back-pressure");
        iIO_buffer_full = 1'b1;
        iST_req = 1'b1; iST_addr = 32'h00030000; iST_len = 3'd1; iST_dt = 32'h00000055;
        iLD_req = 1'b1; iLD_addr = 32'hA00; iLD_len = 3'd4;
        waitGrant("ld4", 32'hA00, 1'b0, 3'd4, 32'h0);
        finishTxn("ld4", 1, 32'h87654321, 3'b010, 32'h0, 32'h87654321);
        iLD_req = 1'b0;
        tick(4);
        checkOutput("st4 blocked", {31'b0, oMC_en}, 32'd0);
        iIO_buffer_full = 1'b0;
        waitGrant("st4", 32'h00030000, 1'b1, 3'd1, 32'h00000055);
        finishTxn("st4", 1, 32'h0, 3'b001, 32'h0, 32'h0);
        iST_req = 1'b0;
        tick(2);

        // Flush during fetch
        $display("[TB] flush");
        iIF_req = 1'b1; iIF_addr = 32'h400;
        waitGrant("if5", 32'h400, 1'b0, 3'd4, 32'h0);
        iFLUSH = 1'b1; iIF_req = 1'b0;
        tick(1);
        iFLUSH = 1'b0;
        finishTxn("if5", 2, 32'hFFFFFFFF, 3'b000, 32'h0, 32'h0);
        iLD_req = 1'b1; iLD_addr = 32'h500; iLD_len = 3'd4;
        waitGrant("ld5", 32'h500, 1'b0, 3'd4, 32'h0);
        finishTxn("ld5", 1, 32'hCAFEF00D, 3'b010, 32'h0, 32'hCAFEF00D);
        iLD_req = 1'b0;
        tick(2);

        // Reset mid-transaction, then a frozen window
        $display("[TB] reset and freeze");
        iLD_req = 1'b1; iLD_addr = 32'h600; iLD_len = 3'd4;
        waitGrant("ld6", 32'h600, 1'b0, 3'd4, 32'h0);
        rst = 1'b1; iLD_req = 1'b0;
        tick(1);
        checkOutput("rst6 en", {31'b0, oMC_en}, 32'd0);
        checkOutput("rst6 done", {29'b0, oIF_done, oLD_done, oST_done}, 32'd0);
        checkOutput("rst6 addr", oMC_addr, 32'd0);
        rst = 1'b0;
        tick(1);
        iLD_req = 1'b1; iLD_addr = 32'h700; iLD_len = 3'd4;
        waitGrant("ld7", 32'h700, 1'b0, 3'd4, 32'h0);
        rdy = 1'b0;
        iMC_done = 1'b1; iMC_dt = 32'h0BADBEEF;
        tick(1);
        iMC_done = 1'b0; iMC_dt = '0;
        tick(3);
        checkOutput("frz en", {31'b0, oMC_en}, 32'd1);
        checkOutput("frz done", {29'b0, oIF_done, oLD_done, oST_done}, 32'd0);
        rdy = 1'b1;
        finishTxn("ld7", 1, 32'h01020304, 3'b010, 32'h0, 32'h01020304);
        iLD_req = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
